// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU codes, FSM state and decoded-control bundle for the
// multicycle control unit.
package cpu_pkg;

  // Opcodes (top four bits of the instruction word)
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_MUL2  = 4'h4;
  localparam logic [3:0] OP_DIV2  = 4'h5;
  localparam logic [3:0] OP_CLR   = 4'h6;
  localparam logic [3:0] OP_RST   = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;
  localparam logic [3:0] OP_LOAD  = 4'hB;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_JZ    = 4'hD;
  localparam logic [3:0] OP_ILL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL2 = 4'b0010;
  localparam logic [3:0] ALU_DIV2 = 4'b0011;
  localparam logic [3:0] ALU_MOV  = 4'b0100;
  localparam logic [3:0] ALU_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // How an instruction finishes after EXEC
  typedef enum logic [2:0] {
    FLOW_SEQ       = 3'd0,  // done in EXEC, advance PC
    FLOW_JMP       = 3'd1,
    FLOW_JZ        = 3'd2,
    FLOW_MEM_OUT   = 3'd3,
    FLOW_MEM_LOAD  = 3'd4,
    FLOW_MEM_STORE = 3'd5,
    FLOW_HALT      = 3'd6,
    FLOW_ILLEGAL   = 3'd7
  } flow_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       load;
    logic       mb_select;
    logic       clr;
    logic       clr_all;
    logic       reg_op;     // drives addr_a/addr_b from rd/rs in EXEC
    flow_t      flow;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:    ALU_IDLE,
    load:      1'b0,
    mb_select: 1'b0,
    clr:       1'b0,
    clr_all:   1'b0,
    reg_op:    1'b0,
    flow:      FLOW_SEQ
  };

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode-to-control-bundle lookup.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Map each opcode onto its EXEC-cycle controls and completion flow
  always_comb begin
    // NOTE: assigning a full default before the case keeps every path driven,
    // so no latch is inferred when a branch only touches a few fields.
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ADD:   begin ctrl.alu_op = ALU_ADD;  ctrl.load = 1'b1; ctrl.mb_select = 1'b1; ctrl.reg_op = 1'b1; end
      OP_SUB:   begin ctrl.alu_op = ALU_SUB;  ctrl.load = 1'b1; ctrl.mb_select = 1'b1; ctrl.reg_op = 1'b1; end
      OP_ADDI:  begin ctrl.alu_op = ALU_ADD;  ctrl.load = 1'b1; ctrl.reg_op = 1'b1; end
      OP_SUBI:  begin ctrl.alu_op = ALU_SUB;  ctrl.load = 1'b1; ctrl.reg_op = 1'b1; end
      OP_MUL2:  begin ctrl.alu_op = ALU_MUL2; ctrl.load = 1'b1; ctrl.reg_op = 1'b1; end
      OP_DIV2:  begin ctrl.alu_op = ALU_DIV2; ctrl.load = 1'b1; ctrl.reg_op = 1'b1; end
      OP_CLR:   begin ctrl.clr = 1'b1;     ctrl.reg_op = 1'b1; end
      OP_RST:   begin ctrl.clr_all = 1'b1; ctrl.reg_op = 1'b1; end
      OP_MOV:   begin ctrl.alu_op = ALU_MOV;  ctrl.load = 1'b1; ctrl.mb_select = 1'b1; ctrl.reg_op = 1'b1; end
      OP_JMP:   ctrl.flow = FLOW_JMP;
      OP_OUT:   ctrl.flow = FLOW_MEM_OUT;
      OP_LOAD:  ctrl.flow = FLOW_MEM_LOAD;
      OP_STORE: ctrl.flow = FLOW_MEM_STORE;
      OP_JZ:    ctrl.flow = FLOW_JZ;
      OP_ILL:   ctrl.flow = FLOW_ILLEGAL;
      OP_HALT:  ctrl.flow = FLOW_HALT;
      default:  ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller: fetch, decode, execute, optional memory access
// and write-back, plus a terminal halt state.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [4+2*REG_AW-1:0]   instruction,
  input  logic                    mem_ready,
  input  logic                    alu_zero,
  output logic                    instr_req,
  output logic [REG_AW-1:0]       addr_a,
  output logic [REG_AW-1:0]       addr_b,
  output logic                    clr,
  output logic                    clr_all,
  output logic                    load,
  output logic                    mb_select,
  output logic [3:0]              alu_opcode,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [2*REG_AW-1:0]     mem_addr,
  output logic                    mem_select,
  output logic                    load_pc,
  output logic [PC_W-1:0]         pc_value,
  output logic                    pc_inc,
  output logic                    halted,
  output logic                    illegal
);

  localparam int OPND_W  = 2 * REG_AW;
  localparam int INSTR_W = 4 + OPND_W;

  state_t               state, state_nxt;
  logic [INSTR_W-1:0]   instr_q;
  logic                 illegal_q;
  ctrl_t                ctrl;

  logic [3:0]           opcode;
  logic [REG_AW-1:0]    rd, rs;
  logic [OPND_W-1:0]    operand;
  logic [PC_W-1:0]      jump_target;

  assign opcode      = instr_q[INSTR_W-1 -: 4];
  assign rd          = instr_q[OPND_W-1:REG_AW];
  assign rs          = instr_q[REG_AW-1:0];
  assign operand     = instr_q[OPND_W-1:0];
  assign jump_target = PC_W'(operand);
  assign illegal     = illegal_q;

  instr_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  // State register, latched instruction and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= FETCH;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && instr_valid)
        instr_q <= instruction;
      if (state == EXEC && ctrl.flow == FLOW_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  // Next-state and output decode from state and latched instruction
  always_comb begin
    state_nxt  = state;
    instr_req  = 1'b0;
    addr_a     = '0;
    addr_b     = '0;
    clr        = 1'b0;
    clr_all    = 1'b0;
    load       = 1'b0;
    mb_select  = 1'b0;
    alu_opcode = ALU_IDLE;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_select = 1'b0;
    load_pc    = 1'b0;
    pc_value   = '0;
    pc_inc     = 1'b0;
    halted     = 1'b0;

    case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_valid)
          state_nxt = DECODE;
      end

      DECODE: state_nxt = EXEC;

      EXEC: begin
        state_nxt  = FETCH;
        alu_opcode = ctrl.alu_op;
        load       = ctrl.load;
        mb_select  = ctrl.mb_select;
        clr        = ctrl.clr;
        clr_all    = ctrl.clr_all;
        if (ctrl.reg_op) begin
          addr_a = rd;
          addr_b = rs;
        end
        case (ctrl.flow)
          FLOW_SEQ, FLOW_ILLEGAL: pc_inc = 1'b1;
          FLOW_JMP: begin
            load_pc  = 1'b1;
            pc_value = jump_target;
          end
          // Conditional branch resolves on the zero flag seen during EXEC
          FLOW_JZ: begin
            if (alu_zero) begin
              load_pc  = 1'b1;
              pc_value = jump_target;
            end else begin
              pc_inc = 1'b1;
            end
          end
          FLOW_MEM_OUT, FLOW_MEM_LOAD, FLOW_MEM_STORE: state_nxt = MEM;
          FLOW_HALT: state_nxt = HALT;
          default: state_nxt = FETCH;
        endcase
      end

      // Strobe held until the memory acknowledges; no timeout by design
      MEM: begin
        mem_addr  = operand;
        mem_read  = (ctrl.flow == FLOW_MEM_OUT) || (ctrl.flow == FLOW_MEM_LOAD);
        mem_write = (ctrl.flow == FLOW_MEM_STORE);
        if (mem_ready) begin
          if (ctrl.flow == FLOW_MEM_LOAD) begin
            state_nxt = WB;
          end else begin
            state_nxt = FETCH;
            pc_inc    = 1'b1;
          end
        end
      end

      // Memory data on Bus D written into register 0
      WB: begin
        load       = 1'b1;
        mem_select = 1'b1;
        pc_inc     = 1'b1;
        state_nxt  = FETCH;
      end

      HALT: halted = 1'b1;

      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: table of single-instruction vectors plus hand-written
// memory, illegal, halt and reset sequences, compared through a queue.
module tb_multicycle_control_unit;
  import cpu_pkg::*;

  localparam int REG_AW = 3;
  localparam int PC_W   = 8;

  logic       clk = 1'b0;
  logic       rst, instr_valid, mem_ready, alu_zero;
  logic [9:0] instruction;

  logic       instr_req, clr, clr_all, load, mb_select, mem_read, mem_write;
  logic       mem_select, load_pc, pc_inc, halted, illegal;
  logic [2:0] addr_a, addr_b;
  logic [3:0] alu_opcode;
  logic [5:0] mem_addr;
  logic [7:0] pc_value;

  multicycle_control_unit #(.REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .instr_req(instr_req),
    .addr_a(addr_a), .addr_b(addr_b), .clr(clr), .clr_all(clr_all),
    .load(load), .mb_select(mb_select), .alu_opcode(alu_opcode),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_select(mem_select), .load_pc(load_pc), .pc_value(pc_value),
    .pc_inc(pc_inc), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       instr_req;
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic       clr;
    logic       clr_all;
    logic       load;
    logic       mb_select;
    logic [3:0] alu_opcode;
    logic       mem_read;
    logic       mem_write;
    logic [5:0] mem_addr;
    logic       mem_select;
    logic       load_pc;
    logic [7:0] pc_value;
    logic       pc_inc;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct {
    string      name;
    logic [9:0] instr;
    logic       zero;
    out_t       exec;
  } vec_t;

  out_t act;
  assign act = {instr_req, addr_a, addr_b, clr, clr_all, load, mb_select,
                alu_opcode, mem_read, mem_write, mem_addr, mem_select,
                load_pc, pc_value, pc_inc, halted, illegal};

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_illegal = 1'b0;
  vec_t vecs[$];

  function automatic out_t idle(input logic req);
    out_t o;
    o            = '0;
    o.instr_req  = req;
    o.alu_opcode = 4'hF;
    o.illegal    = exp_illegal;
    return o;
  endfunction

  function automatic out_t mk_exec(input logic [3:0] alu, input logic [2:0] a,
                                   input logic [2:0] b, input logic ld,
                                   input logic mb, input logic c, input logic ca,
                                   input logic lpc, input logic [7:0] pcv,
                                   input logic inc);
    out_t o;
    o            = idle(1'b0);
    o.alu_opcode = alu;
    o.addr_a     = a;
    o.addr_b     = b;
    o.load       = ld;
    o.mb_select  = mb;
    o.clr        = c;
    o.clr_all    = ca;
    o.load_pc    = lpc;
    o.pc_value   = pcv;
    o.pc_inc     = inc;
    return o;
  endfunction

  task automatic check(input string name, input out_t e);
    n_checks++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, e);
  endtask

  // Push the expectation for the current cycle, compare at the falling edge,
  // then advance to just after the next rising edge.
  task automatic step(input out_t e, input string name);
    exp_q.push_back(e);
    @(negedge clk);
    check(name, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // FETCH cycle with the word presented, then the DECODE cycle
  task automatic fetch_decode(input logic [9:0] word, input string name);
    instruction = word;
    instr_valid = 1'b1;
    step(idle(1'b1), {name, "_fetch"});
    instr_valid = 1'b0;
    step(idle(1'b0), {name, "_decode"});
  endtask

  task automatic apply_vec(input vec_t v);
    out_t e;
    alu_zero = v.zero;
    fetch_decode(v.instr, v.name);
    e         = v.exec;
    e.illegal = exp_illegal;
    step(e, {v.name, "_exec"});
  endtask

  initial begin
    out_t e;
    vecs.push_back('{"add",    10'b0000_001_010, 1'b0, mk_exec(4'h0, 3'd1, 3'd2, 1, 1, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"sub",    10'b0001_011_100, 1'b0, mk_exec(4'h1, 3'd3, 3'd4, 1, 1, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"addi",   10'b0010_101_110, 1'b1, mk_exec(4'h0, 3'd5, 3'd6, 1, 0, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"subi",   10'b0011_111_001, 1'b0, mk_exec(4'h1, 3'd7, 3'd1, 1, 0, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"mul2",   10'b0100_010_000, 1'b0, mk_exec(4'h2, 3'd2, 3'd0, 1, 0, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"div2",   10'b0101_100_011, 1'b0, mk_exec(4'h3, 3'd4, 3'd3, 1, 0, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"clr",    10'b0110_110_000, 1'b0, mk_exec(4'hF, 3'd6, 3'd0, 0, 0, 1, 0, 0, 8'd0,  1)});
    vecs.push_back('{"rstall", 10'b0111_000_000, 1'b0, mk_exec(4'hF, 3'd0, 3'd0, 0, 0, 0, 1, 0, 8'd0,  1)});
    vecs.push_back('{"mov",    10'b1000_001_111, 1'b0, mk_exec(4'h4, 3'd1, 3'd7, 1, 1, 0, 0, 0, 8'd0,  1)});
    vecs.push_back('{"jmp",    10'b1001_101_010, 1'b0, mk_exec(4'hF, 3'd0, 3'd0, 0, 0, 0, 0, 1, 8'd42, 0)});
    vecs.push_back('{"jz_t",   10'b1101_010_000, 1'b1, mk_exec(4'hF, 3'd0, 3'd0, 0, 0, 0, 0, 1, 8'd16, 0)});
    vecs.push_back('{"jz_nt",  10'b1101_010_000, 1'b0, mk_exec(4'hF, 3'd0, 3'd0, 0, 0, 0, 0, 0, 8'd0,  1)});

    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
    instruction = '0;
    @(posedge clk); #1;
    step(idle(1'b1), "reset_state");
    rst = 1'b0;

    // Idle fetch: no valid word keeps requesting
    step(idle(1'b1), "fetch_stall0");
    step(idle(1'b1), "fetch_stall1");

    foreach (vecs[i]) apply_vec(vecs[i]);
    alu_zero = 1'b0;
    step(idle(1'b1), "after_table_fetch");

    // LOAD with three wait cycles, then write-back
    fetch_decode(10'b1011_000101, "load");
    step(idle(1'b0), "load_exec");
    e = idle(1'b0); e.mem_read = 1'b1; e.mem_addr = 6'd5;
    for (int i = 0; i < 3; i++) step(e, "load_mem_wait");
    mem_ready = 1'b1;
    step(e, "load_mem_ready");
    mem_ready = 1'b0;
    e = idle(1'b0); e.load = 1'b1; e.mem_select = 1'b1; e.pc_inc = 1'b1;
    step(e, "load_wb");
    step(idle(1'b1), "load_done_fetch");

    // OUT: one wait, advances PC on the acknowledge cycle
    fetch_decode(10'b1010_000111, "out");
    step(idle(1'b0), "out_exec");
    e = idle(1'b0); e.mem_read = 1'b1; e.mem_addr = 6'd7;
    step(e, "out_mem_wait");
    mem_ready = 1'b1;
    e.pc_inc = 1'b1;
    step(e, "out_mem_ready");
    mem_ready = 1'b0;
    step(idle(1'b1), "out_done_fetch");

    // Illegal opcode behaves as a NOP and sets the sticky flag
    fetch_decode(10'b1110_000000, "ill");
    e = idle(1'b0); e.pc_inc = 1'b1;
    step(e, "ill_exec");
    exp_illegal = 1'b1;
    apply_vec(vecs[0]);

    // HALT: stays halted for 20 cycles even with valid words offered
    fetch_decode(10'b1111_000000, "halt");
    step(idle(1'b0), "halt_exec");
    instr_valid = 1'b1;
    e = idle(1'b0); e.halted = 1'b1;
    for (int i = 0; i < 20; i++) step(e, "halted");
    rst = 1'b1;
    step(e, "halt_rst_cycle");
    rst = 1'b0;
    exp_illegal = 1'b0;
    instr_valid = 1'b0;
    step(idle(1'b1), "halt_after_rst");

    // Reset during a STORE wait
    fetch_decode(10'b1100_000011, "store");
    step(idle(1'b0), "store_exec");
    e = idle(1'b0); e.mem_write = 1'b1; e.mem_addr = 6'd3;
    step(e, "store_mem_wait0");
    rst = 1'b1;
    step(e, "store_mem_rst_cycle");
    rst = 1'b0;
    step(idle(1'b1), "store_after_rst");

    // Reset beats mem_ready: LOAD must not reach write-back
    fetch_decode(10'b1011_000001, "load_rst");
    step(idle(1'b0), "load_rst_exec");
    rst = 1'b1; mem_ready = 1'b1;
    e = idle(1'b0); e.mem_read = 1'b1; e.mem_addr = 6'd1;
    step(e, "load_rst_mem");
    rst = 1'b0; mem_ready = 1'b0;
    step(idle(1'b1), "load_rst_fetch");

    // Reset beats instr_valid: still in FETCH afterwards
    rst = 1'b1; instr_valid = 1'b1; instruction = 10'b0000_001_010;
    step(idle(1'b1), "rst_vs_valid");
    rst = 1'b0; instr_valid = 1'b0;
    step(idle(1'b1), "rst_vs_valid_fetch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
